wb_merge: RTL and testbench

- Writeback merge stage directly upstream of the dual-write-port register file.
- Takes two in-order ALU lane results and a stream of long-latency results (mul/div/load).
- Long-latency results wait in a small FIFO until a write port is free.
- Drives both RF write buses from registered outputs and exports a pending-register vector for the issue stage's hazard check.

---
 rtl/wb_merge.sv | 136 +++++++++++++
 tb/tb_wb_merge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_merge.sv
// Writeback merge: two in-order ALU lanes plus a long-latency FIFO
// steered onto the two register-file write ports.
module wb_merge #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       p0_valid,
  input  logic [4:0]                 p0_waddr,
  input  logic [XLEN-1:0]            p0_wdata,
  input  logic                       p1_valid,
  input  logic [4:0]                 p1_waddr,
  input  logic [XLEN-1:0]            p1_wdata,
  input  logic                       ll_valid,
  output logic                       ll_ready,
  input  logic [4:0]                 ll_waddr,
  input  logic [XLEN-1:0]            ll_wdata,
  output logic                       rf_bus_0_wen,
  output logic [4:0]                 rf_bus_0_waddr,
  output logic [XLEN-1:0]            rf_bus_0_wdata,
  output logic                       rf_bus_1_wen,
  output logic [4:0]                 rf_bus_1_waddr,
  output logic [XLEN-1:0]            rf_bus_1_wdata,
  output logic [31:0]                pending,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      mem_addr [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            rst_done;

  logic            lane0;
  logic            lane1;
  logic            take0;
  logic            take1;
  logic            enq;
  logic [CW-1:0]   deq;
  logic [PW-1:0]   idx1;

  assign fifo_count = count;
  assign ll_ready   = reset && rst_done && (count < CW'(DEPTH));

  // Only entries present before this edge are eligible: no bypass.
  always_comb begin
    lane0 = p0_valid && (p0_waddr != 5'd0);
    lane1 = p1_valid && (p1_waddr != 5'd0);
    take0 = !lane0 && (count != '0);
    take1 = !lane1 && (count > CW'(take0));
    idx1  = take0 ? rd_ptr + PW'(1) : rd_ptr;
    deq   = CW'(take0) + CW'(take1);
    enq   = ll_valid && ll_ready && (ll_waddr != 5'd0);
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      mem_addr[wr_ptr] <= ll_waddr;
      mem_data[wr_ptr] <= ll_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rst_done       <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      rf_bus_0_wen   <= 1'b0;
      rf_bus_0_waddr <= '0;
      rf_bus_0_wdata <= '0;
      rf_bus_1_wen   <= 1'b0;
      rf_bus_1_waddr <= '0;
      rf_bus_1_wdata <= '0;
    end else begin
      rst_done <= 1'b1;
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr + PW'(deq);
      count  <= count + CW'(enq) - deq;

      rf_bus_0_wen   <= lane0 || take0;
      rf_bus_0_waddr <= '0;
      rf_bus_0_wdata <= '0;
      if (lane0) begin
        rf_bus_0_waddr <= p0_waddr;
        rf_bus_0_wdata <= p0_wdata;
      end else if (take0) begin
        rf_bus_0_waddr <= mem_addr[rd_ptr];
        rf_bus_0_wdata <= mem_data[rd_ptr];
      end

      rf_bus_1_wen   <= lane1 || take1;
      rf_bus_1_waddr <= '0;
      rf_bus_1_wdata <= '0;
      if (lane1) begin
        rf_bus_1_waddr <= p1_waddr;
        rf_bus_1_wdata <= p1_wdata;
      end else if (take1) begin
        rf_bus_1_waddr <= mem_addr[idx1];
        rf_bus_1_wdata <= mem_data[idx1];
      end
    end
  end

  logic [31:0]   pend;
  logic [PW-1:0] off;

  // An entry is live when its distance from the head is below count.
  always_comb begin
    pend = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if ({1'b0, off} < count) begin
        pend[mem_addr[i]] = 1'b1;
      end
    end
    if (rf_bus_0_wen) begin
      pend[rf_bus_0_waddr] = 1'b1;
    end
    if (rf_bus_1_wen) begin
      pend[rf_bus_1_waddr] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign pending = pend;

endmodule

// File: tb/tb_wb_merge.sv
// Directed table-driven bench for wb_merge
// plus hand-written reset sequences.
module tb_wb_merge;

  logic        clock = 1'b0;
  logic        reset;
  logic        p0_valid;
  logic [4:0]  p0_waddr;
  logic [63:0] p0_wdata;
  logic        p1_valid;
  logic [4:0]  p1_waddr;
  logic [63:0] p1_wdata;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_waddr;
  logic [63:0] ll_wdata;
  logic        rf_bus_0_wen;
  logic [4:0]  rf_bus_0_waddr;
  logic [63:0] rf_bus_0_wdata;
  logic        rf_bus_1_wen;
  logic [4:0]  rf_bus_1_waddr;
  logic [63:0] rf_bus_1_wdata;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  always #5 clock = ~clock;

  wb_merge #(.XLEN(64), .DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .p0_valid(p0_valid),
    .p0_waddr(p0_waddr),
    .p0_wdata(p0_wdata),
    .p1_valid(p1_valid),
    .p1_waddr(p1_waddr),
    .p1_wdata(p1_wdata),
    .ll_valid(ll_valid),
    .ll_ready(ll_ready),
    .ll_waddr(ll_waddr),
    .ll_wdata(ll_wdata),
    .rf_bus_0_wen(rf_bus_0_wen),
    .rf_bus_0_waddr(rf_bus_0_waddr),
    .rf_bus_0_wdata(rf_bus_0_wdata),
    .rf_bus_1_wen(rf_bus_1_wen),
    .rf_bus_1_waddr(rf_bus_1_waddr),
    .rf_bus_1_wdata(rf_bus_1_wdata),
    .pending(pending),
    .fifo_count(fifo_count)
  );

  typedef struct {
    logic        p0v;
    logic [4:0]  p0a;
    logic [63:0] p0d;
    logic        p1v;
    logic [4:0]  p1a;
    logic [63:0] p1d;
    logic        llv;
    logic [4:0]  lla;
    logic [63:0] lld;
    logic        w0;
    logic [4:0]  a0;
    logic [63:0] d0;
    logic        w1;
    logic [4:0]  a1;
    logic [63:0] d1;
    logic [2:0]  cnt;
    logic        rdy;
    logic [31:0] pnd;
  } vec_t;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  vec_t        tbl[$];
  int          ncmp = 0;
  int          nfail = 0;
  logic [63:0] rf [32];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Downstream RF model: bus 1 is applied after bus 0.
  task automatic step();
    @(posedge clock);
    #1;
    if (rf_bus_0_wen) rf[rf_bus_0_waddr] = rf_bus_0_wdata;
    if (rf_bus_1_wen) rf[rf_bus_1_waddr] = rf_bus_1_wdata;
  endtask

  task automatic drive(logic a, logic [4:0] b, logic [63:0] c,
                       logic d, logic [4:0] e, logic [63:0] f,
                       logic g, logic [4:0] h, logic [63:0] k);
    p0_valid = a; p0_waddr = b; p0_wdata = c;
    p1_valid = d; p1_waddr = e; p1_wdata = f;
    ll_valid = g; ll_waddr = h; ll_wdata = k;
  endtask

  task automatic idle_chk(string nm, logic rdy);
    chk({nm, ".w0"}, 64'(rf_bus_0_wen), 64'(1'b0));
    chk({nm, ".w1"}, 64'(rf_bus_1_wen), 64'(1'b0));
    chk({nm, ".pnd"}, 64'(pending), 64'(32'h0));
    chk({nm, ".cnt"}, 64'(fifo_count), 64'(3'd0));
    chk({nm, ".rdy"}, 64'(ll_ready), 64'(rdy));
  endtask

  initial begin
    // p0 | p1 | ll inputs, then bus0 | bus1 | count rdy pending after the edge
    tbl.push_back('{T,5'd5,64'h11, T,5'd6,64'h22, F,5'd0,64'h0, T,5'd5,64'h11, T,5'd6,64'h22, 3'd0,T,32'h60});
    tbl.push_back('{T,5'd7,64'hA, T,5'd7,64'hB, F,5'd0,64'h0, T,5'd7,64'hA, T,5'd7,64'hB, 3'd0,T,32'h80});
    tbl.push_back('{F,5'd0,64'h0, F,5'd0,64'h0, T,5'd1,64'h1, F,5'd0,64'h0, F,5'd0,64'h0, 3'd1,T,32'h2});
    tbl.push_back('{F,5'd0,64'h0, F,5'd0,64'h0, F,5'd0,64'h0, T,5'd1,64'h1, F,5'd0,64'h0, 3'd0,T,32'h2});
    tbl.push_back('{T,5'd10,64'h100, T,5'd11,64'h101, T,5'd1,64'h1, T,5'd10,64'h100, T,5'd11,64'h101, 3'd1,T,32'hC02});
    tbl.push_back('{T,5'd10,64'h100, T,5'd11,64'h101, T,5'd2,64'h2, T,5'd10,64'h100, T,5'd11,64'h101, 3'd2,T,32'hC06});
    tbl.push_back('{T,5'd10,64'h100, T,5'd11,64'h101, T,5'd3,64'h3, T,5'd10,64'h100, T,5'd11,64'h101, 3'd3,T,32'hC0E});
    tbl.push_back('{F,5'd0,64'h0, F,5'd0,64'h0, F,5'd0,64'h0, T,5'd1,64'h1, T,5'd2,64'h2, 3'd1,T,32'hE});
    tbl.push_back('{F,5'd0,64'h0, F,5'd0,64'h0, F,5'd0,64'h0, T,5'd3,64'h3, F,5'd0,64'h0, 3'd0,T,32'h8});
    tbl.push_back('{F,5'd0,64'h0, F,5'd0,64'h0, F,5'd0,64'h0, F,5'd0,64'h0, F,5'd0,64'h0, 3'd0,T,32'h0});
    tbl.push_back('{T,5'd10,64'h100, T,5'd11,64'h101, T,5'd12,64'h12, T,5'd10,64'h100, T,5'd11,64'h101, 3'd1,T,32'h1C00});
    tbl.push_back('{T,5'd10,64'h100, T,5'd11,64'h101, T,5'd13,64'h13, T,5'd10,64'h100, T,5'd11,64'h101, 3'd2,T,32'h3C00});
    tbl.push_back('{T,5'd10,64'h100, T,5'd11,64'h101, T,5'd14,64'h14, T,5'd10,64'h100, T,5'd11,64'h101, 3'd3,T,32'h7C00});
    tbl.push_back('{T,5'd10,64'h100, T,5'd11,64'h101, T,5'd15,64'h15, T,5'd10,64'h100, T,5'd11,64'h101, 3'd4,F,32'hFC00});
    tbl.push_back('{T,5'd10,64'h100, T,5'd11,64'h101, T,5'd16,64'h16, T,5'd10,64'h100, T,5'd11,64'h101, 3'd4,F,32'hFC00});
    tbl.push_back('{T,5'd10,64'h100, F,5'd11,64'h101, T,5'd16,64'h16, T,5'd10,64'h100, T,5'd12,64'h12, 3'd3,T,32'hF400});
    tbl.push_back('{T,5'd10,64'h100, T,5'd11,64'h101, T,5'd16,64'h16, T,5'd10,64'h100, T,5'd11,64'h101, 3'd4,F,32'h1EC00});
    tbl.push_back('{F,5'd0,64'h0, F,5'd0,64'h0, F,5'd0,64'h0, T,5'd13,64'h13, T,5'd14,64'h14, 3'd2,T,32'h1E000});
    tbl.push_back('{F,5'd0,64'h0, F,5'd0,64'h0, T,5'd0,64'hDEAD, T,5'd15,64'h15, T,5'd16,64'h16, 3'd0,T,32'h18000});
    tbl.push_back('{F,5'd0,64'h0, F,5'd0,64'h0, F,5'd0,64'h0, F,5'd0,64'h0, F,5'd0,64'h0, 3'd0,T,32'h0});
    tbl.push_back('{F,5'd0,64'h0, F,5'd0,64'h0, T,5'd20,64'h20, F,5'd0,64'h0, F,5'd0,64'h0, 3'd1,T,32'h100000});
    tbl.push_back('{T,5'd0,64'h99, T,5'd21,64'h21, F,5'd0,64'h0, T,5'd20,64'h20, T,5'd21,64'h21, 3'd0,T,32'h300000});
    tbl.push_back('{T,5'd0,64'h55, T,5'd0,64'h66, F,5'd0,64'h0, F,5'd0,64'h0, F,5'd0,64'h0, 3'd0,T,32'h0});

    for (int i = 0; i < 32; i++) rf[i] = 64'h0;

    reset = 1'b0;
    drive(T, 5'd5, 64'h1, T, 5'd6, 64'h2, T, 5'd9, 64'h3);
    for (int i = 0; i < 3; i++) begin
      step();
      idle_chk($sformatf("rst%0d", i), 1'b0);
    end
    reset = 1'b1;
    drive(F, 5'd0, 64'h0, F, 5'd0, 64'h0, F, 5'd0, 64'h0);
    step();
    idle_chk("release", 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      string n;
      t = tbl[i];
      n = $sformatf("row%0d", i);
      drive(t.p0v, t.p0a, t.p0d, t.p1v, t.p1a, t.p1d, t.llv, t.lla, t.lld);
      step();
      chk({n, ".w0"}, 64'(rf_bus_0_wen), 64'(t.w0));
      chk({n, ".a0"}, 64'(rf_bus_0_waddr), 64'(t.a0));
      chk({n, ".d0"}, rf_bus_0_wdata, t.d0);
      chk({n, ".w1"}, 64'(rf_bus_1_wen), 64'(t.w1));
      chk({n, ".a1"}, 64'(rf_bus_1_waddr), 64'(t.a1));
      chk({n, ".d1"}, rf_bus_1_wdata, t.d1);
      chk({n, ".cnt"}, 64'(fifo_count), 64'(t.cnt));
      chk({n, ".rdy"}, 64'(ll_ready), 64'(t.rdy));
      chk({n, ".pnd"}, 64'(pending), 64'(t.pnd));
    end
    chk("rf_x7_lane1_wins", rf[7], 64'hB);

    // Mid-operation reset with three buffered entries.
    for (int i = 1; i <= 3; i++) begin
      drive(T, 5'd10, 64'h100, T, 5'd11, 64'h101,
            T, 5'(i), 64'(i));
      step();
    end
    chk("mid.cnt_before", 64'(fifo_count), 64'(3'd3));
    chk("mid.pnd_before", 64'(pending), 64'(32'hC0E));
    drive(F, 5'd0, 64'h0, F, 5'd0, 64'h0, F, 5'd0, 64'h0);
    reset = 1'b0;
    step();
    idle_chk("mid.rst", 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      idle_chk($sformatf("mid.after%0d", i), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
